fifo_ms_drain: RTL and testbench
================================

Name: fifo_ms_drain

Overview:
- Reader-side companion to the multi-stream tagged FIFO.
- Watches the FIFO's per-flux empty flags and issues one-hot reads, choosing among fluxes round-robin.
- Registers each popped word into a single valid/ready output stage, splitting the word into data and tag, and keeps per-flux statistics.
- Sits between the multi-stream FIFO read port and a single downstream consumer.

Parameters:
DATA_WIDTH, 8, payload width excluding tag
FLUX, 2, number of streams; must be >= 2
CNT_WIDTH, 16, width of per-flux forwarded-word counters
TAG_WIDTH, $clog2(FLUX), derived; tag field width
WIDTH, DATA_WIDTH+TAG_WIDTH, derived; FIFO word width, tag in the MSBs

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
fifo_empty  in  FLUX  per-flux empty flags from the FIFO
fifo_read  out  FLUX  one-hot read strobe to the FIFO; the FIFO pointer advances at the next edge
fifo_dout  in  WIDTH  FIFO output word; combinationally reflects the flux selected by fifo_read
flux_en  in  FLUX  per-flux enable mask; a disabled flux is never granted
out_valid  out  1  output stage holds a word
out_ready  in  1  downstream accepts the word when out_valid && out_ready
out_data  out  DATA_WIDTH  payload, fifo_dout[DATA_WIDTH-1:0]
out_tag  out  TAG_WIDTH  index of the flux the word came from
fwd_cnt  out  FLUX*CNT_WIDTH  packed per-flux count of popped words; flux k occupies bits [k*CNT_WIDTH +: CNT_WIDTH]
err_tag  out  FLUX  sticky; bit k set if a word popped from flux k carried a tag != k

Behaviour:
- Reset (rst low, asynchronous):
  - out_valid=0, out_data=0, out_tag=0, fwd_cnt=0, err_tag=0.
  - Last-grant pointer = FLUX-1, so flux 0 is served first after reset.
  - fifo_read is forced to 0 combinationally while rst is low.
- A flux k is eligible when !fifo_empty[k] && flux_en[k].
- can_pop = !out_valid || out_ready.
- Grant: the first eligible flux searching cyclically from last_grant+1 (modulo FLUX).
- fifo_read = one-hot(grant) when can_pop and at least one flux is eligible, else 0.
  - Never more than one bit set.
  - Never set for an empty or disabled flux.
- Pop cycle, i.e. fifo_read != 0 (registered at the edge):
  - out_data <= fifo_dout[DATA_WIDTH-1:0].
  - out_tag <= grant index.
  - out_valid <= 1.
  - last_grant <= grant.
  - fwd_cnt[grant] increments.
  - err_tag[grant] is set if fifo_dout[WIDTH-1 -: TAG_WIDTH] != grant. The word is still forwarded.
- No-pop cycle with out_valid && out_ready: out_valid <= 0; out_data and out_tag hold their last values.
- Backpressure (out_valid && !out_ready): out_valid, out_data and out_tag are held stable, and fifo_read=0.
- Throughput: one word per cycle while out_ready=1 and any flux is eligible.
- Latency: one cycle from the fifo_read assertion to out_valid.
- Fairness: with k eligible fluxes and continuous out_ready, each eligible flux is served at least once every k pops.
- The last-grant pointer updates only on a pop. Idle cycles do not rotate priority.
- flux_en changes take effect in the same cycle's grant computation. Already-popped words are unaffected.
- fwd_cnt wraps modulo 2^CNT_WIDTH with no saturation.
- err_tag clears only on reset.
- Combinational path out_ready -> fifo_read is intentional.
  - The downstream must not derive out_ready combinationally from fifo_read.
  - The FIFO's read-to-dout path is combinational; the integrator closes timing.
- Reset asserted mid-transfer: the held output word is discarded with no replay. FIFO pointers are the FIFO's concern.

Decomposition:
- Shared package: TAG_WIDTH/WIDTH derivation function and a word-split typedef (struct of tag, data).
- Sub-module rr_arbiter (FLUX-wide request, one-hot grant, last-grant register with a load enable), reused later by the write-side mux.
- Output stage, counters and tag check live in fifo_ms_drain.

Test Plan:
1. Reset check -> after rst low then high with all fifo_empty=1: out_valid=0, fifo_read=0, fwd_cnt=0, err_tag=0.
2. Round-robin order -> FLUX=2, flux0 holds {0,0x11},{0,0x22}, flux1 holds {1,0x33}, out_ready=1.
   - Required: out_data 0x11/t0, 0x33/t1, 0x22/t0 on consecutive cycles.
   - Required: fwd_cnt = {1,2}.
3. Backpressure -> out_ready=0 for 3 cycles while out_valid=1.
   - Required: fifo_read=0 throughout; out_data stable.
   - Required: the pop resumes in the same cycle out_ready rises.
4. Enable mask -> flux_en=2'b10, both fluxes non-empty.
   - Required: only fifo_read=2'b10 is ever issued.
   - Required: flux0 is served on the first pop after flux_en returns to 2'b11.
5. Tag error -> flux1 word with tag 0.
   - Required: err_tag=2'b10 from the next cycle and sticky; word still output with out_tag=1.
6. Async reset mid-stream -> rst low between edges while out_valid=1.
   - Required: out_valid drops immediately with no edge; after release, the first grant goes to flux 0.

Source files
------------

// File: rtl/fifo_ms_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ms_drain_pkg
//  Description : Shared width helpers and word layout for the multi-stream
//                FIFO drain logic and its round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_ms_drain_pkg;

  // Tag field width for a given stream count; a single stream still keeps a
  // one-bit tag so the word layout never collapses to zero width.
  function automatic int calc_tag_width(input int flux);
    return (flux <= 1) ? 1 : $clog2(flux);
  endfunction

  // Full FIFO word width: payload plus tag, with the tag in the MSBs.
  function automatic int calc_word_width(input int data_width, input int flux);
    return data_width + calc_tag_width(flux);
  endfunction

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FLUX       = 2;
  localparam int DEF_TAG_WIDTH  = calc_tag_width(DEF_FLUX);
  localparam int DEF_WIDTH      = calc_word_width(DEF_DATA_WIDTH, DEF_FLUX);

  // Word split for the default configuration (tag above data). Modules
  // that are parameterised declare the same layout with their own widths.
  typedef struct packed {
    logic [DEF_TAG_WIDTH-1:0]  tag;
    logic [DEF_DATA_WIDTH-1:0] data;
  } word_split_t;

endpackage : fifo_ms_drain_pkg
`default_nettype wire

// File: rtl/fifo_ms_drain_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : N-way round-robin arbiter. Searches cyclically from the
//                stream after the last grant; the last-grant pointer moves
//                only when the caller asserts i_load.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import fifo_ms_drain_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = calc_tag_width(N)
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic [N-1:0]     i_req,
  input  logic             i_load,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] r_last;
  logic [N-1:0]     w_grant;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_found;
  int               w_cand;

  // Pick the first requester at or after last+1, wrapping modulo N.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = 0;
    for (int off = 1; off <= N; off++) begin
      w_cand = (int'(r_last) + off) % N;
      if (!w_found && i_req[w_cand]) begin
        w_found              = 1'b1;
        w_grant[w_cand]      = 1'b1;
        w_grant_idx          = IDX_W'(w_cand);
      end
    end
  end

  // Last-grant pointer; resets to N-1 so stream 0 wins the first search.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= IDX_W'(N - 1);
    end else if (i_load) begin
      r_last <= w_grant_idx;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_grant_idx;
  assign o_any       = w_found;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fifo_ms_drain.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ms_drain
//  Description : Reader-side companion of the multi-stream tagged FIFO.
//                Round-robin one-hot reads, a single valid/ready output
//                register splitting each word into data and tag, per-stream
//                forwarded-word counters and sticky tag-mismatch flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ms_drain
  import fifo_ms_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int CNT_WIDTH  = 16,
  parameter int TAG_WIDTH  = calc_tag_width(FLUX),
  parameter int WIDTH      = calc_word_width(DATA_WIDTH, FLUX)
) (
  input  logic                      clk,
  input  logic                      rst,          // asynchronous, active-low
  input  logic [FLUX-1:0]           fifo_empty,
  output logic [FLUX-1:0]           fifo_read,
  input  logic [WIDTH-1:0]          fifo_dout,
  input  logic [FLUX-1:0]           flux_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic [FLUX*CNT_WIDTH-1:0] fwd_cnt,
  output logic [FLUX-1:0]           err_tag
);

  // Same layout as the package split type, sized by this instance.
  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } w_word_t;

  w_word_t               w_word;
  logic [FLUX-1:0]       w_elig;
  logic                  w_can_pop;
  logic                  w_pop;
  logic [FLUX-1:0]       w_grant;
  logic [TAG_WIDTH-1:0]  w_grant_idx;
  logic                  w_any;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [CNT_WIDTH-1:0]  r_cnt [FLUX];
  logic                  r_err [FLUX];

  assign w_word    = w_word_t'(fifo_dout);
  assign w_elig    = ~fifo_empty & flux_en;
  assign w_can_pop = !r_valid || out_ready;

  // Holding rst low keeps the FIFO pointers still regardless of clocking.
  assign w_pop     = rst && w_can_pop && w_any;
  assign fifo_read = w_pop ? w_grant : '0;

  rr_arbiter #(
    .N     (FLUX),
    .IDX_W (TAG_WIDTH)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (w_elig),
    .i_load      (w_pop),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // Output register: load on a pop, retire on accept, hold under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_data  <= w_word.data;
      r_tag   <= w_grant_idx;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  for (genvar k = 0; k < FLUX; k++) begin : g_flux

    // Forwarded-word counter; wraps freely.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt[k] <= '0;
      end else if (w_pop && w_grant[k]) begin
        r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
      end
    end

    // Sticky flag for a word whose embedded tag disagrees with its stream.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_err[k] <= 1'b0;
      end else if (w_pop && w_grant[k] && (w_word.tag != TAG_WIDTH'(k))) begin
        r_err[k] <= 1'b1;
      end
    end

    assign fwd_cnt[k*CNT_WIDTH +: CNT_WIDTH] = r_cnt[k];
    assign err_tag[k]                        = r_err[k];
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_tag   = r_tag;

endmodule : fifo_ms_drain
`default_nettype wire

// File: tb/tb_fifo_ms_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_ms_drain
//  Description : Self-checking bench for fifo_ms_drain. A simple array FIFO
//                model feeds the DUT; a cycle-level reference model predicts
//                reads and outputs from the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ms_drain;

  localparam int DW    = 8;
  localparam int FLUX  = 2;
  localparam int CW    = 16;
  localparam int TW    = 1;
  localparam int W     = DW + TW;
  localparam int DEPTH = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic [FLUX-1:0]    fifo_empty;
  logic [FLUX-1:0]    fifo_read;
  logic [W-1:0]       fifo_dout;
  logic [FLUX-1:0]    flux_en;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [TW-1:0]      out_tag;
  logic [FLUX*CW-1:0] fwd_cnt;
  logic [FLUX-1:0]    err_tag;

  fifo_ms_drain #(
    .DATA_WIDTH (DW),
    .FLUX       (FLUX),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fifo_dout  (fifo_dout),
    .flux_en    (flux_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .fwd_cnt    (fwd_cnt),
    .err_tag    (err_tag)
  );

  always #5 clk = ~clk;

  // ---------------- FIFO stand-in ----------------
  logic [W-1:0] mem [FLUX][DEPTH];
  int           head [FLUX];
  int           tail [FLUX];

  always_comb begin
    fifo_empty = '0;
    for (int k = 0; k < FLUX; k++) fifo_empty[k] = (head[k] == tail[k]);
  end

  always_comb begin
    fifo_dout = '0;
    for (int k = 0; k < FLUX; k++)
      if (fifo_read[k]) fifo_dout = mem[k][head[k] % DEPTH];
  end

  always @(posedge clk) begin
    for (int k = 0; k < FLUX; k++)
      if (fifo_read[k]) head[k] <= head[k] + 1;
  end

  task automatic push(input int k, input logic [TW-1:0] t, input logic [DW-1:0] d);
    mem[k][tail[k] % DEPTH] = {t, d};
    tail[k] = tail[k] + 1;
  endtask

  // ---------------- reference model ----------------
  int            mdl_last;
  logic          mdl_valid;
  logic [DW-1:0] mdl_data;
  logic [TW-1:0] mdl_tag;
  logic [CW-1:0] mdl_cnt [FLUX];
  logic [FLUX-1:0] mdl_err;
  logic [FLUX-1:0] seen_read;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    mdl_last  = FLUX - 1;
    mdl_valid = 1'b0;
    mdl_data  = '0;
    mdl_tag   = '0;
    mdl_err   = '0;
    for (int k = 0; k < FLUX; k++) mdl_cnt[k] = '0;
  endtask

  // Round-robin rule: first non-empty enabled stream after the last winner.
  function automatic logic [FLUX-1:0] exp_read();
    logic [FLUX-1:0] r;
    r = '0;
    if (rst && (!mdl_valid || out_ready)) begin
      for (int off = 1; off <= FLUX; off++) begin
        int k;
        k = (mdl_last + off) % FLUX;
        if (r == '0 && head[k] != tail[k] && flux_en[k]) r[k] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [FLUX*CW-1:0] exp_cnt();
    logic [FLUX*CW-1:0] e;
    for (int k = 0; k < FLUX; k++) e[k*CW +: CW] = mdl_cnt[k];
    return e;
  endfunction

  // One clock: inputs are set by the caller at the negedge before this call.
  task automatic cycle();
    logic [FLUX-1:0] er;
    logic [W-1:0]    ew;
    int              g;
    ew = '0;
    g  = -1;
    #1;
    er = exp_read();
    seen_read = fifo_read;
    chk("fifo_read", fifo_read, er);
    for (int k = 0; k < FLUX; k++) if (er[k]) g = k;
    if (g >= 0) ew = mem[g][head[g] % DEPTH];
    @(posedge clk);
    if (g >= 0) begin
      mdl_valid = 1'b1;
      mdl_data  = ew[DW-1:0];
      mdl_tag   = TW'(g);
      mdl_last  = g;
      mdl_cnt[g] = mdl_cnt[g] + 1'b1;
      if (ew[W-1 -: TW] != TW'(g)) mdl_err[g] = 1'b1;
    end else if (mdl_valid && out_ready) begin
      mdl_valid = 1'b0;
    end
    @(negedge clk);
    chk("out_valid", out_valid, mdl_valid);
    chk("out_data", out_data, mdl_data);
    chk("out_tag", out_tag, mdl_tag);
    chk("fwd_cnt", fwd_cnt, exp_cnt());
    chk("err_tag", err_tag, mdl_err);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    out_ready = 1'b1;
    flux_en   = '1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (fifo_empty == '1 && !mdl_valid) done = 1'b1;
      else cycle();
    end
    chk("drain_bound", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    flux_en   = '1;
    out_ready = 1'b0;
    seen_read = '0;
    for (int k = 0; k < FLUX; k++) tail[k] = 0;
    mdl_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    // 1. reset state
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_read", fifo_read, '0);
    chk("rst_cnt", fwd_cnt, '0);
    chk("rst_err", err_tag, '0);
    chk("rst_data", out_data, '0);
    @(negedge clk);

    // 2. round-robin order
    push(0, 1'b0, 8'h11); push(0, 1'b0, 8'h22); push(1, 1'b1, 8'h33);
    out_ready = 1'b1;
    cycle(); chk("rr0_data", out_data, 8'h11); chk("rr0_tag", out_tag, 1'b0);
    cycle(); chk("rr1_data", out_data, 8'h33); chk("rr1_tag", out_tag, 1'b1);
    cycle(); chk("rr2_data", out_data, 8'h22); chk("rr2_tag", out_tag, 1'b0);
    chk("rr_cnt", fwd_cnt, 32'h0001_0002);
    drain();

    // 3. backpressure
    push(0, 1'b0, 8'hA1); push(0, 1'b0, 8'hA2);
    out_ready = 1'b1;
    cycle(); chk("bp_first", out_data, 8'hA1);
    out_ready = 1'b0;
    repeat (3) begin
      cycle();
      chk("bp_read", seen_read, 2'b00);
      chk("bp_data", out_data, 8'hA1);
      chk("bp_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    cycle(); chk("bp_resume", seen_read, 2'b01); chk("bp_next", out_data, 8'hA2);
    drain();

    // 4. enable mask
    push(0, 1'b0, 8'hB0); push(0, 1'b0, 8'hB1);
    push(1, 1'b1, 8'hC0); push(1, 1'b1, 8'hC1);
    flux_en = 2'b10;
    repeat (3) begin
      cycle();
      chk("mask_read", seen_read & 2'b01, 2'b00);
    end
    flux_en = 2'b11;
    cycle(); chk("mask_resume", seen_read, 2'b01);
    drain();

    // 5. tag error
    push(1, 1'b0, 8'h55);
    cycle();
    chk("tagerr_flag", err_tag, 2'b10);
    chk("tagerr_tag", out_tag, 1'b1);
    chk("tagerr_data", out_data, 8'h55);
    cycle(); cycle();
    chk("tagerr_sticky", err_tag, 2'b10);
    drain();

    // 6. asynchronous reset mid-stream
    push(0, 1'b0, 8'hD0); push(0, 1'b0, 8'hD1);
    push(1, 1'b1, 8'hE0); push(1, 1'b1, 8'hE1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();
    chk("arst_pre_valid", out_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_read", fifo_read, '0);
    chk("arst_cnt", fwd_cnt, '0);
    chk("arst_err", err_tag, '0);
    mdl_reset();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    cycle(); chk("arst_first_grant", seen_read, 2'b01);
    drain();

    // 7. randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < FLUX; k++) begin
        if ($urandom_range(0, 2) == 0 && (tail[k] - head[k]) < DEPTH - 4) begin
          logic [TW-1:0] t;
          t = TW'(k);
          if ($urandom_range(0, 15) == 0) t = t ^ TW'(1);
          push(k, t, DW'($urandom));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flux_en   = ($urandom_range(0, 4) == 0) ? FLUX'($urandom) : '1;
      cycle();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_fifo_ms_drain
`default_nettype wire
